// File: rtl/decode_stage.sv
// RV32I decode stage and ID/EX pipeline register, with a one-entry load-use scoreboard.
// Latency: 1 cycle from accept to ex_valid_o. Backpressure: holds the bundle while ex_ready_i is low, and stalls intake on load-use hazards.
package decode_pkg;
    localparam int ALU_OP_WIDTH    = 4;
    localparam int IMM_MUX_WIDTH   = 3;
    localparam int WDATA_MUX_WIDTH = 2;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
        ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [1:0] OP_A_REG = 2'd0, OP_A_PC = 2'd1, OP_A_ZERO = 2'd2;
    localparam logic       OP_B_REG = 1'b0, OP_B_IMM = 1'b1;
    localparam logic [IMM_MUX_WIDTH-1:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2,
        IMM_U = 3'd3, IMM_J = 3'd4, IMM_Z = 3'd5;
    localparam logic [2:0] BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
        BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6;
    localparam logic [WDATA_MUX_WIDTH-1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC4 = 2'd2;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]    alu_op;
        logic [1:0]                 data_a_mux;
        logic                       data_b_mux;
        logic [IMM_MUX_WIDTH-1:0]   imm_mux;
        logic [2:0]                 branch_op;
        logic                       jal_op;
        logic                       jalr_op;
        logic [WDATA_MUX_WIDTH-1:0] wdata_mux;
        logic                       reg_we;
        logic                       mem_we;
        logic                       mem_re;
        logic [1:0]                 mem_size;
        logic                       mem_unsigned;
        logic                       illegal;
    } ctrl_t;
endpackage

module decode_stage import decode_pkg::*; #(
    parameter int ADDR_WIDTH   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int ILLEGAL_EN   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    input  logic [31:0]                instr_i,
    input  logic [31:0]                pc_i,
    input  logic                       flush_i,
    input  logic                       ex_ready_i,
    output logic                       ex_valid_o,
    output logic [31:0]                pc_o,
    output logic [ALU_OP_WIDTH-1:0]    alu_op_o,
    output logic [1:0]                 data_a_mux_o,
    output logic                       data_b_mux_o,
    output logic [IMM_MUX_WIDTH-1:0]   imm_mux_o,
    output logic [2:0]                 branch_op_o,
    output logic                       jal_op_o,
    output logic                       jalr_op_o,
    output logic [WDATA_MUX_WIDTH-1:0] wdata_mux_o,
    output logic                       reg_we_o,
    output logic [ADDR_WIDTH-1:0]      rd_o,
    output logic [ADDR_WIDTH-1:0]      rs1_o,
    output logic [ADDR_WIDTH-1:0]      rs2_o,
    output logic                       mem_we_o,
    output logic                       mem_re_o,
    output logic [1:0]                 mem_size_o,
    output logic                       mem_unsigned_o,
    output logic                       illegal_o
);
    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F,
        OPC_JALR = 7'h67, OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
        OPC_OP_IMM = 7'h13, OPC_OP = 7'h33, OPC_FENCE = 7'h0F, OPC_SYSTEM = 7'h73;
    localparam logic [1:0] LD_LAT = 2'(LOAD_LATENCY);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] rd, rs1, rs2;
    logic                  funct7_ok;
    logic [ALU_OP_WIDTH-1:0] alu_rr;
    ctrl_t                 dec, ctrl_q;
    logic                  legal, use_rs1, use_rs2;
    logic                  rdy_en, full, hazard, accept;
    logic [1:0]            ld_cnt;
    logic [ADDR_WIDTH-1:0] ld_rd, rd_q, rs1_q, rs2_q;
    logic [31:0]           pc_q;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign rd        = ADDR_WIDTH'(instr_i[11:7]);
    assign rs1       = ADDR_WIDTH'(instr_i[19:15]);
    assign rs2       = ADDR_WIDTH'(instr_i[24:20]);
    assign funct7_ok = (instr_i[31] == 1'b0) && (instr_i[29:25] == 5'd0);

    // Bit 30 selects SUB only for register-register ops; shifts use it for SRA in both forms.
    always_comb begin
        alu_rr = ALU_ADD;
        case (funct3)
            3'b000:  alu_rr = (opcode == OPC_OP && instr_i[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_rr = ALU_SLL;
            3'b010:  alu_rr = ALU_SLT;
            3'b011:  alu_rr = ALU_SLTU;
            3'b100:  alu_rr = ALU_XOR;
            3'b101:  alu_rr = instr_i[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_rr = ALU_OR;
            default: alu_rr = ALU_AND;
        endcase
    end

    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.data_a_mux = OP_A_ZERO; dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_U;
                dec.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.data_a_mux = OP_A_PC; dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_U;
                dec.reg_we = 1'b1;
            end
            OPC_JAL: begin
                dec.data_a_mux = OP_A_PC; dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_J;
                dec.jal_op = 1'b1; dec.wdata_mux = WD_PC4; dec.reg_we = 1'b1;
            end
            OPC_JALR: begin
                dec.data_a_mux = OP_A_REG; dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_I;
                dec.jalr_op = 1'b1; dec.wdata_mux = WD_PC4; dec.reg_we = 1'b1;
                use_rs1 = 1'b1; legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.data_a_mux = OP_A_PC; dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_B;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec.branch_op = BR_EQ;
                    3'b001:  dec.branch_op = BR_NE;
                    3'b100:  dec.branch_op = BR_LT;
                    3'b101:  dec.branch_op = BR_GE;
                    3'b110:  dec.branch_op = BR_LTU;
                    3'b111:  dec.branch_op = BR_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_I; dec.mem_re = 1'b1;
                dec.wdata_mux = WD_MEM; dec.reg_we = 1'b1;
                dec.mem_size = funct3[1:0]; dec.mem_unsigned = funct3[2];
                use_rs1 = 1'b1; legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_S; dec.mem_we = 1'b1;
                dec.mem_size = funct3[1:0];
                use_rs1 = 1'b1; use_rs2 = 1'b1; legal = (funct3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_I; dec.alu_op = alu_rr;
                dec.reg_we = 1'b1; use_rs1 = 1'b1;
            end
            OPC_OP: begin
                dec.data_b_mux = OP_B_REG; dec.alu_op = alu_rr; dec.reg_we = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                legal = funct7_ok && (!instr_i[30] || funct3 == 3'b000 || funct3 == 3'b101);
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                // Treated as a NOP; only the CSR immediate select is hinted for EX.
                dec.data_b_mux = OP_B_IMM; dec.imm_mux = IMM_Z;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
            dec.illegal = (ILLEGAL_EN != 0);
        end
        if (instr_i[11:7] == 5'd0) dec.reg_we = 1'b0;
    end

    assign hazard = (ld_cnt != 2'd0) && (ld_rd != '0) &&
                    ((use_rs1 && rs1 == ld_rd) || (use_rs2 && rs2 == ld_rd));
    assign instr_ready_o = rdy_en && (!full || ex_ready_i) && !hazard && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_en <= 1'b0;
            full   <= 1'b0;
            ld_cnt <= 2'd0;
            ld_rd  <= '0;
            pc_q   <= '0;
            ctrl_q <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush_i)         full <= 1'b0;
            else if (accept)     full <= 1'b1;
            else if (ex_ready_i) full <= 1'b0;

            if (accept) begin
                pc_q   <= pc_i;
                ctrl_q <= dec;
                rd_q   <= rd;
                rs1_q  <= rs1;
                rs2_q  <= rs2;
            end

            if (flush_i) begin
                ld_cnt <= 2'd0;
            end else if (accept && dec.mem_re) begin
                ld_cnt <= LD_LAT;
                ld_rd  <= rd;
            end else if (ld_cnt != 2'd0) begin
                ld_cnt <= ld_cnt - 2'd1;
            end
        end
    end

    assign ex_valid_o     = full;
    assign pc_o           = pc_q;
    assign alu_op_o       = ctrl_q.alu_op;
    assign data_a_mux_o   = ctrl_q.data_a_mux;
    assign data_b_mux_o   = ctrl_q.data_b_mux;
    assign imm_mux_o      = ctrl_q.imm_mux;
    assign branch_op_o    = ctrl_q.branch_op;
    assign jal_op_o       = ctrl_q.jal_op;
    assign jalr_op_o      = ctrl_q.jalr_op;
    assign wdata_mux_o    = ctrl_q.wdata_mux;
    assign reg_we_o       = ctrl_q.reg_we;
    assign rd_o           = rd_q;
    assign rs1_o          = rs1_q;
    assign rs2_o          = rs2_q;
    assign mem_we_o       = ctrl_q.mem_we;
    assign mem_re_o       = ctrl_q.mem_re;
    assign mem_size_o     = ctrl_q.mem_size;
    assign mem_unsigned_o = ctrl_q.mem_unsigned;
    assign illegal_o      = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, load-use stall, backpressure, flush, decode and reset.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk, rst_n, instr_valid, flush, ex_ready;
    logic [31:0] instr, pc;
    logic        instr_ready, ex_valid, data_b_mux, jal_op, jalr_op, reg_we;
    logic        mem_we, mem_re, mem_unsigned, illegal;
    logic [31:0] pc_o;
    logic [3:0]  alu_op;
    logic [1:0]  data_a_mux, wdata_mux, mem_size;
    logic [2:0]  imm_mux, branch_op;
    logic [4:0]  rd, rs1, rs2;
    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] I_ADDI  = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] I_LW    = 32'h0000A183;  // lw   x3,0(x1)
    localparam logic [31:0] I_USE   = 32'h00318233;  // add  x4,x3,x3
    localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] I_USE0  = 32'h00000233;  // add  x4,x0,x0
    localparam logic [31:0] I_BEQ   = 32'h00208063;  // beq  x1,x2,0

    decode_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(ex_valid), .pc_o(pc_o), .alu_op_o(alu_op), .data_a_mux_o(data_a_mux),
        .data_b_mux_o(data_b_mux), .imm_mux_o(imm_mux), .branch_op_o(branch_op),
        .jal_op_o(jal_op), .jalr_op_o(jalr_op), .wdata_mux_o(wdata_mux), .reg_we_o(reg_we),
        .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_size_o(mem_size), .mem_unsigned_o(mem_unsigned), .illegal_o(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one packet, let it be accepted, then leave the input idle with the bundle visible.
    task automatic send(input logic [31:0] ins, input logic [31:0] p);
        instr_valid = 1'b1; instr = ins; pc = p;
        tick();
        instr_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; ex_ready = 1'b1;
        #3 rst_n = 1'b0;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
        checks++; if ({pc_o, alu_op, reg_we, mem_re, illegal, rd} !== '0) begin fails++; $display("FAIL reset_bundle: pc %h alu %h we %b re %b ill %b rd %0d want all 0", pc_o, alu_op, reg_we, mem_re, illegal, rd); end
        rst_n = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL release_ready_early: got %b want 0", instr_ready); end
        tick();
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_stream();
        instr_valid = 1'b1; instr = I_ADDI; pc = 32'h100;
        #1;
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL stream_ready: got %b want 1", instr_ready); end
        tick();
        instr = I_ADD; pc = 32'h104;
        #1;
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h100) begin fails++; $display("FAIL stream_first: valid %b pc %h want 1 00000100", ex_valid, pc_o); end
        checks++; if (rd !== 5'd1 || reg_we !== 1'b1 || data_b_mux !== OP_B_IMM || imm_mux !== IMM_I || rs1 !== 5'd0) begin fails++; $display("FAIL stream_addi: rd %0d we %b bmux %b imm %0d rs1 %0d want 1 1 1 0 0", rd, reg_we, data_b_mux, imm_mux, rs1); end
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL stream_ready2: got %b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h104) begin fails++; $display("FAIL stream_second: valid %b pc %h want 1 00000104", ex_valid, pc_o); end
        checks++; if (alu_op !== ALU_ADD || rs1 !== 5'd1 || rs2 !== 5'd1 || rd !== 5'd2 || data_b_mux !== OP_B_REG) begin fails++; $display("FAIL stream_add: alu %0d rs1 %0d rs2 %0d rd %0d bmux %b want 0 1 1 2 0", alu_op, rs1, rs2, rd, data_b_mux); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: got %b want 0", ex_valid); end
    endtask

    task automatic test_load_use();
        instr_valid = 1'b1; instr = I_LW; pc = 32'h200;
        tick();
        instr = I_USE; pc = 32'h204;
        #1;
        checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL lu_stall: ready %b want 0", instr_ready); end
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h200 || mem_re !== 1'b1 || mem_size !== 2'd2 || wdata_mux !== WD_MEM) begin fails++; $display("FAIL lu_load: valid %b pc %h re %b size %0d wd %0d", ex_valid, pc_o, mem_re, mem_size, wdata_mux); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble: valid %b want 0", ex_valid); end
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL lu_resume: ready %b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h204 || rs1 !== 5'd3 || rd !== 5'd4) begin fails++; $display("FAIL lu_issue: valid %b pc %h rs1 %0d rd %0d", ex_valid, pc_o, rs1, rd); end
        tick();
        instr_valid = 1'b1; instr = I_LW0; pc = 32'h300;
        tick();
        instr = I_USE0; pc = 32'h304;
        #1;
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL lu_x0_nostall: ready %b want 1", instr_ready); end
        checks++; if (reg_we !== 1'b0 || mem_re !== 1'b1) begin fails++; $display("FAIL lu_x0_we: we %b re %b want 0 1", reg_we, mem_re); end
        tick();
        instr_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h304) begin fails++; $display("FAIL lu_x0_issue: valid %b pc %h", ex_valid, pc_o); end
        tick();
    endtask

    task automatic test_backpressure();
        instr_valid = 1'b1; instr = I_ADDI; pc = 32'h400;
        tick();
        ex_ready = 1'b0; instr = I_ADD; pc = 32'h404;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h400 || rd !== 5'd1 || instr_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d: valid %b pc %h rd %0d ready %b", i, ex_valid, pc_o, rd, instr_ready); end
            tick();
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1 || pc_o !== 32'h400) begin fails++; $display("FAIL bp_release: ready %b pc %h", instr_ready, pc_o); end
        tick();
        instr_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h404 || rd !== 5'd2) begin fails++; $display("FAIL bp_next: valid %b pc %h rd %0d", ex_valid, pc_o, rd); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL bp_nodup: valid %b want 0", ex_valid); end
    endtask

    task automatic test_flush();
        instr_valid = 1'b1; instr = I_LW; pc = 32'h500;
        tick();
        instr = I_USE; pc = 32'h504;
        #1;
        checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL fl_hazard: ready %b want 0", instr_ready); end
        ex_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        #1;
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL fl_kill: valid %b want 0", ex_valid); end
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL fl_nostall: ready %b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b1 || pc_o !== 32'h504) begin fails++; $display("FAIL fl_next: valid %b pc %h", ex_valid, pc_o); end
        instr_valid = 1'b1; instr = I_ADDI; pc = 32'h600; flush = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL fl_ready: ready %b want 0", instr_ready); end
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || pc_o !== 32'h504) begin fails++; $display("FAIL fl_drop: valid %b pc %h want 0 00000504", ex_valid, pc_o); end
    endtask

    task automatic test_branches();
        logic [2:0] f3_tab [6];
        logic [2:0] op_tab [6];
        f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        op_tab = '{BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
        for (int i = 0; i < 6; i++) begin
            send(I_BEQ | (32'(f3_tab[i]) << 12), 32'h800 + 32'(i * 4));
            checks++; if (ex_valid !== 1'b1 || branch_op !== op_tab[i] || reg_we !== 1'b0 || jal_op !== 1'b0 || imm_mux !== IMM_B || data_a_mux !== OP_A_PC || illegal !== 1'b0) begin fails++; $display("FAIL br_f3_%0d: valid %b op %0d want %0d we %b jal %b imm %0d a %0d ill %b", f3_tab[i], ex_valid, branch_op, op_tab[i], reg_we, jal_op, imm_mux, data_a_mux, illegal); end
        end
        send(I_BEQ | 32'h00002000, 32'h900);
        checks++; if (ex_valid !== 1'b1 || illegal !== 1'b1 || reg_we !== 1'b0 || branch_op !== BR_NONE) begin fails++; $display("FAIL br_f3_010: valid %b ill %b we %b op %0d want 1 1 0 0", ex_valid, illegal, reg_we, branch_op); end
        send(32'h0000017F, 32'h904);
        checks++; if (ex_valid !== 1'b1 || illegal !== 1'b1 || reg_we !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || jalr_op !== 1'b0) begin fails++; $display("FAIL opc_7f: valid %b ill %b we %b mw %b mr %b jalr %b", ex_valid, illegal, reg_we, mem_we, mem_re, jalr_op); end
        tick();
    endtask

    task automatic test_decode_misc();
        send(32'h123452B7, 32'hA00);  // lui x5
        checks++; if (data_a_mux !== OP_A_ZERO || imm_mux !== IMM_U || reg_we !== 1'b1 || rd !== 5'd5 || illegal !== 1'b0) begin fails++; $display("FAIL lui: a %0d imm %0d we %b rd %0d ill %b", data_a_mux, imm_mux, reg_we, rd, illegal); end
        send(32'h12345297, 32'hA04);  // auipc x5
        checks++; if (data_a_mux !== OP_A_PC || imm_mux !== IMM_U || reg_we !== 1'b1) begin fails++; $display("FAIL auipc: a %0d imm %0d we %b", data_a_mux, imm_mux, reg_we); end
        send(32'h000100E7, 32'hA08);  // jalr x1,0(x2)
        checks++; if (jalr_op !== 1'b1 || jal_op !== 1'b0 || wdata_mux !== WD_PC4 || data_a_mux !== OP_A_REG || imm_mux !== IMM_I || reg_we !== 1'b1) begin fails++; $display("FAIL jalr: jalr %b jal %b wd %0d a %0d imm %0d we %b", jalr_op, jal_op, wdata_mux, data_a_mux, imm_mux, reg_we); end
        send(32'h000000EF, 32'hA0C);  // jal x1,0
        checks++; if (jal_op !== 1'b1 || wdata_mux !== WD_PC4 || imm_mux !== IMM_J || data_a_mux !== OP_A_PC) begin fails++; $display("FAIL jal: jal %b wd %0d imm %0d a %0d", jal_op, wdata_mux, imm_mux, data_a_mux); end
        send(32'h40108133, 32'hA10);  // sub x2,x1,x1
        checks++; if (alu_op !== ALU_SUB) begin fails++; $display("FAIL sub: alu %0d want %0d", alu_op, ALU_SUB); end
        send(32'h4030D393, 32'hA14);  // srai x7,x1,3
        checks++; if (alu_op !== ALU_SRA) begin fails++; $display("FAIL srai: alu %0d want %0d", alu_op, ALU_SRA); end
        send(32'h40309393, 32'hA18);  // slli with bit 30 set
        checks++; if (alu_op !== ALU_SLL || illegal !== 1'b0) begin fails++; $display("FAIL slli30: alu %0d ill %b want %0d 0", alu_op, illegal, ALU_SLL); end
        send(32'h0020A223, 32'hA1C);  // sw x2,4(x1)
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || reg_we !== 1'b0 || mem_size !== 2'd2 || imm_mux !== IMM_S) begin fails++; $display("FAIL sw: mw %b mr %b we %b size %0d imm %0d", mem_we, mem_re, reg_we, mem_size, imm_mux); end
        send(32'h0000C303, 32'hA20);  // lbu x6,0(x1)
        checks++; if (mem_re !== 1'b1 || mem_size !== 2'd0 || mem_unsigned !== 1'b1 || wdata_mux !== WD_MEM || reg_we !== 1'b1) begin fails++; $display("FAIL lbu: mr %b size %0d uns %b wd %0d we %b", mem_re, mem_size, mem_unsigned, wdata_mux, reg_we); end
        tick();
    endtask

    task automatic test_reset_mid();
        instr_valid = 1'b1; instr = I_ADDI; pc = 32'h700;
        tick();
        instr = I_ADD; pc = 32'h704;
        #1;
        checks++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL rm_pre: valid %b want 1", ex_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || instr_ready !== 1'b0 || pc_o !== 32'h0 || rd !== 5'd0 || reg_we !== 1'b0) begin fails++; $display("FAIL rm_async: valid %b ready %b pc %h rd %0d we %b want all 0", ex_valid, instr_ready, pc_o, rd, reg_we); end
        instr_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL rm_release_early: ready %b want 0", instr_ready); end
        tick();
        checks++; if (instr_ready !== 1'b1 || ex_valid !== 1'b0) begin fails++; $display("FAIL rm_release: ready %b valid %b want 1 0", instr_ready, ex_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_backpressure();
        test_flush();
        test_branches();
        test_decode_misc();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
